// File: rtl/hyperram_seq.sv
// rtl/hyperram_seq.sv - HyperRAM linear-burst transaction sequencer feeding the DDR I/O buffer.
// Optional: define HRAM_VARLAT_EN to take the initial latency from rwds_in sampled during CA1.
module hyperram_seq #(
  parameter int ADDR_W = 22,
  parameter int LAT    = 6,
  parameter int RD_DLY = 3,
  parameter int TRWR   = 3
) (
  input  logic              clk0_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  output logic              ack_o,
  input  logic [15:0]       wdata_i,
  output logic              wready_o,
  output logic [15:0]       rdata_o,
  output logic              rvalid_o,
  output logic              done_o,
  output logic [15:0]       io_datain_o,
  input  logic [15:0]       io_dataout_i,
  output logic              io_oe_clk_o,
  output logic              io_oe_data_o,
  output logic              cs_n_o,
  output logic              rwds_oe_o,
  output logic              rwds_out_o,
  input  logic              rwds_in_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_CA0, S_CA1, S_CA2, S_LATW, S_WDATA, S_RDATA, S_HOLD, S_RECOV
  } state_t;

  localparam logic [8:0] LAT_LONG_LAST  = 9'(2 * LAT - 2);
  localparam logic [8:0] LAT_SHORT_LAST = 9'(LAT - 2);
  localparam logic [8:0] RECOV_LAST     = 9'(TRWR - 1);
  // Every pipe stage except the output one; HOLD may exit while the last token is emerging.
  localparam logic [RD_DLY-1:0] LOW_MASK = RD_DLY'((1 << (RD_DLY - 1)) - 1);

  state_t              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic                done_q, done_d;
  logic                lat_long_q;
  logic [RD_DLY-1:0]   pipe_q;
  logic                push;
  logic                lat_long;
  logic [8:0]          lat_last;
  logic [47:0]         ca;

  assign ca = {~we_q, 1'b0, 1'b1, {(29 - (ADDR_W - 3)){1'b0}}, addr_q[ADDR_W-1:3], 13'b0, addr_q[2:0]};

`ifdef HRAM_VARLAT_EN
  assign lat_long = lat_long_q;
`else
  // Without variable latency the sampled RWDS has no effect: always double latency.
  assign lat_long = lat_long_q | 1'b1;
`endif

  assign lat_last = lat_long ? LAT_LONG_LAST : LAT_SHORT_LAST;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    push         = 1'b0;
    ack_o        = 1'b0;
    cs_n_o       = 1'b1;
    io_oe_clk_o  = 1'b0;
    io_oe_data_o = 1'b0;
    io_datain_o  = 16'h0000;
    rwds_oe_o    = 1'b0;
    rwds_out_o   = 1'b0;
    wready_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The IDLE-entry cycle carries done; a held request is taken one cycle later.
        if (req_i && !done_q && !rst_i) begin
          ack_o   = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cs_n_o  = 1'b0;
        state_d = S_CA0;
      end
      S_CA0, S_CA1, S_CA2: begin
        cs_n_o       = 1'b0;
        io_oe_clk_o  = 1'b1;
        io_oe_data_o = 1'b1;
        if (state_q == S_CA0) begin
          io_datain_o = ca[47:32];
          state_d     = S_CA1;
        end else if (state_q == S_CA1) begin
          io_datain_o = ca[31:16];
          state_d     = S_CA2;
        end else begin
          io_datain_o = ca[15:0];
          cnt_d       = 9'd0;
          state_d     = S_LATW;
        end
      end
      S_LATW: begin
        cs_n_o      = 1'b0;
        io_oe_clk_o = 1'b1;
        if (cnt_q == lat_last) begin
          cnt_d   = 9'd0;
          state_d = we_q ? S_WDATA : S_RDATA;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_WDATA, S_RDATA: begin
        cs_n_o      = 1'b0;
        io_oe_clk_o = 1'b1;
        if (state_q == S_WDATA) begin
          io_oe_data_o = 1'b1;
          rwds_oe_o    = 1'b1;
          wready_o     = 1'b1;
          io_datain_o  = wdata_i;
        end else begin
          push = 1'b1;
        end
        if (cnt_q == {1'b0, len_q}) begin
          cnt_d   = 9'd0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_HOLD: begin
        cs_n_o = 1'b0;
        if ((pipe_q & LOW_MASK) == '0) begin
          cnt_d   = 9'd0;
          state_d = S_RECOV;
        end
      end
      S_RECOV: begin
        if (cnt_q == RECOV_LAST) begin
          cnt_d   = 9'd0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk0_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 9'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= 8'd0;
      done_q     <= 1'b0;
      lat_long_q <= 1'b0;
      pipe_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pipe_q  <= (pipe_q << 1) | RD_DLY'(push);
      if (ack_o) begin
        we_q   <= we_i;
        addr_q <= addr_i;
        len_q  <= len_i;
      end
      if (state_q == S_CA1) begin
        lat_long_q <= rwds_in_i;
      end
    end
  end

  assign rvalid_o = pipe_q[RD_DLY-1];
  assign rdata_o  = pipe_q[RD_DLY-1] ? io_dataout_i : 16'h0000;
  assign done_o   = done_q;

endmodule

// File: tb/tb_hyperram_seq.sv
// tb/tb_hyperram_seq.sv - directed self-checking bench for hyperram_seq with a read-latency device model.
module tb_hyperram_seq;
  localparam int ADDR_W = 22;
  localparam int LAT    = 6;
  localparam int RD_DLY = 3;
  localparam int TRWR   = 3;

  logic              clk0_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_i = 1'b0;
  logic              we_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [7:0]        len_i = 8'd0;
  logic              ack_o;
  logic [15:0]       wdata_i = 16'h0;
  logic              wready_o;
  logic [15:0]       rdata_o;
  logic              rvalid_o;
  logic              done_o;
  logic [15:0]       io_datain_o;
  logic [15:0]       io_dataout_i;
  logic              io_oe_clk_o;
  logic              io_oe_data_o;
  logic              cs_n_o;
  logic              rwds_oe_o;
  logic              rwds_out_o;
  logic              rwds_in_i = 1'b0;

  hyperram_seq #(.ADDR_W(ADDR_W), .LAT(LAT), .RD_DLY(RD_DLY), .TRWR(TRWR)) dut (
    .clk0_i(clk0_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .len_i(len_i),
    .ack_o(ack_o), .wdata_i(wdata_i), .wready_o(wready_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .done_o(done_o), .io_datain_o(io_datain_o), .io_dataout_i(io_dataout_i),
    .io_oe_clk_o(io_oe_clk_o), .io_oe_data_o(io_oe_data_o), .cs_n_o(cs_n_o),
    .rwds_oe_o(rwds_oe_o), .rwds_out_o(rwds_out_o), .rwds_in_i(rwds_in_i)
  );

  always #5 clk0_i = ~clk0_i;

  int n_cmp = 0;
  int n_err = 0;

  // Device model: clock-only cycles after the latency are data cycles; word k returns RD_DLY cycles later.
  int          exp_lat = 2 * LAT - 1;
  logic [15:0] rd_base = 16'h0;
  int          m_oc = 0;
  int          m_k = 0;
  logic [16:0] dl [0:RD_DLY] = '{default: 17'h0};

  always @(posedge clk0_i) begin
    #2;
    for (int i = RD_DLY; i > 0; i--) dl[i] = dl[i-1];
    if (cs_n_o) begin
      m_oc = 0;
      m_k = 0;
      dl[0] = 17'h0;
    end else if (io_oe_clk_o && !io_oe_data_o) begin
      if (m_oc >= exp_lat) begin
        dl[0] = {1'b1, rd_base + 16'(m_k)};
        m_k++;
      end else begin
        dl[0] = 17'h0;
      end
      m_oc++;
    end else begin
      dl[0] = 17'h0;
    end
    io_dataout_i = dl[RD_DLY][16] ? dl[RD_DLY][15:0] : 16'hDEAD;
  end

  int          ack_n, done_n, ca_n, oc_n, wr_n, wr_err, rv_n, rv_err, rv_gap, rv_first, rv_last;
  int          ack_c [0:1];
  int          done_c [0:1];
  int          rise_c, fall2_c;
  logic [15:0] ca [0:2];

  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                         input int n_txn, input int maxc);
    logic prev_csn;
    ack_n = 0; done_n = 0; ca_n = 0; oc_n = 0; wr_n = 0; wr_err = 0;
    rv_n = 0; rv_err = 0; rv_gap = 0; rv_first = -1; rv_last = -1;
    ack_c[0] = -1; ack_c[1] = -1; done_c[0] = -1; done_c[1] = -1;
    rise_c = -1; fall2_c = -1;
    ca[0] = 16'h0; ca[1] = 16'h0; ca[2] = 16'h0;
    prev_csn = 1'b1;
    @(posedge clk0_i); #1;
    req_i = 1'b1; we_i = we; addr_i = addr; len_i = len; wdata_i = 16'hA001;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk0_i);
      if (ack_o) begin
        if (ack_n < 2) ack_c[ack_n] = c;
        ack_n++;
      end
      if (!cs_n_o && io_oe_data_o && !wready_o && ca_n < 3) begin
        ca[ca_n] = io_datain_o;
        ca_n++;
      end
      if (ack_n <= 1 && !cs_n_o && io_oe_clk_o && !io_oe_data_o) oc_n++;
      if (wready_o) begin
        if (io_datain_o !== 16'hA001 + 16'(wr_n) || rwds_oe_o !== 1'b1 || rwds_out_o !== 1'b0) wr_err++;
        wr_n++;
      end
      if (rvalid_o) begin
        if (rdata_o !== rd_base + 16'(rv_n)) rv_err++;
        if (rv_n > 0 && c != rv_last + 1) rv_gap++;
        if (rv_n == 0) rv_first = c;
        rv_last = c;
        rv_n++;
      end
      if (!prev_csn && cs_n_o && rise_c < 0) rise_c = c;
      if (prev_csn && !cs_n_o && rise_c >= 0 && fall2_c < 0) fall2_c = c;
      prev_csn = cs_n_o;
      if (done_o) begin
        if (done_n < 2) done_c[done_n] = c;
        done_n++;
      end
      if (done_n >= n_txn) break;
      @(posedge clk0_i); #1;
      if (ack_n >= n_txn) req_i = 1'b0;
      wdata_i = 16'hA001 + 16'(wr_n);
    end
    req_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    req_i = 1'b1;
    repeat (3) @(posedge clk0_i);
    @(negedge clk0_i);
    n_cmp++; if (cs_n_o !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b want 1", cs_n_o); end
    n_cmp++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    n_cmp++; if ({wready_o, rvalid_o, done_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {wready_o, rvalid_o, done_o}); end
    n_cmp++; if ({io_oe_clk_o, io_oe_data_o, rwds_oe_o, rwds_out_o} !== 4'b0000) begin n_err++; $display("FAIL reset_oe: got %b want 0000", {io_oe_clk_o, io_oe_data_o, rwds_oe_o, rwds_out_o}); end
    n_cmp++; if (io_datain_o !== 16'h0) begin n_err++; $display("FAIL reset_datain: got %h want 0000", io_datain_o); end
    n_cmp++; if (rdata_o !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", rdata_o); end
    @(posedge clk0_i); #1;
    rst_i = 1'b0;
    req_i = 1'b0;
    repeat (2) @(posedge clk0_i);
  endtask

  task automatic test_write;
    exp_lat = 2 * LAT - 1;
    run_txn(1'b1, 22'h12345, 8'd3, 1, 100);
    n_cmp++; if (ack_c[0] !== 0 || ack_n !== 1) begin n_err++; $display("FAIL wr_ack: got cyc %0d n %0d want cyc 0 n 1", ack_c[0], ack_n); end
    n_cmp++; if (ca[0] !== 16'h2000) begin n_err++; $display("FAIL wr_ca0: got %h want 2000", ca[0]); end
    n_cmp++; if (ca[1] !== 16'h2468) begin n_err++; $display("FAIL wr_ca1: got %h want 2468", ca[1]); end
    n_cmp++; if (ca[2] !== 16'h0005) begin n_err++; $display("FAIL wr_ca2: got %h want 0005", ca[2]); end
    n_cmp++; if (oc_n !== 11) begin n_err++; $display("FAIL wr_latency: got %0d want 11", oc_n); end
    n_cmp++; if (wr_n !== 4 || wr_err !== 0) begin n_err++; $display("FAIL wr_data: got %0d words %0d bad want 4 words 0 bad", wr_n, wr_err); end
    n_cmp++; if (done_c[0] !== 24 || done_n !== 1) begin n_err++; $display("FAIL wr_done: got cyc %0d n %0d want cyc 24 n 1", done_c[0], done_n); end
    n_cmp++; if (rv_n !== 0) begin n_err++; $display("FAIL wr_no_rvalid: got %0d want 0", rv_n); end
  endtask

  task automatic test_read_single;
    exp_lat = 2 * LAT - 1;
    rd_base = 16'hBEEF;
    run_txn(1'b0, 22'h00010, 8'd0, 1, 100);
    n_cmp++; if (ca[0] !== 16'hA000) begin n_err++; $display("FAIL rd_ca0: got %h want A000", ca[0]); end
    n_cmp++; if (ca[1] !== 16'h0002 || ca[2] !== 16'h0000) begin n_err++; $display("FAIL rd_ca12: got %h %h want 0002 0000", ca[1], ca[2]); end
    n_cmp++; if (rv_n !== 1 || rv_err !== 0) begin n_err++; $display("FAIL rd_word: got %0d words %0d bad want 1 word 0 bad", rv_n, rv_err); end
    n_cmp++; if (rv_first !== 19) begin n_err++; $display("FAIL rd_rvalid_cyc: got %0d want 19", rv_first); end
    n_cmp++; if (rise_c !== 20) begin n_err++; $display("FAIL rd_cs_rise: got %0d want 20", rise_c); end
    n_cmp++; if (done_c[0] !== 23) begin n_err++; $display("FAIL rd_done: got %0d want 23", done_c[0]); end
  endtask

  task automatic test_back_to_back;
    exp_lat = 2 * LAT - 1;
    rd_base = 16'h7000;
    run_txn(1'b0, 22'h00020, 8'd0, 2, 120);
    n_cmp++; if (ack_c[0] !== 0 || ack_c[1] !== 24) begin n_err++; $display("FAIL b2b_acks: got %0d %0d want 0 24", ack_c[0], ack_c[1]); end
    n_cmp++; if (done_c[0] !== 23 || done_c[1] !== 47) begin n_err++; $display("FAIL b2b_dones: got %0d %0d want 23 47", done_c[0], done_c[1]); end
    n_cmp++; if (fall2_c - rise_c !== TRWR + 2) begin n_err++; $display("FAIL b2b_cs_high: got %0d want %0d", fall2_c - rise_c, TRWR + 2); end
    n_cmp++; if (ack_n !== 2) begin n_err++; $display("FAIL b2b_ack_count: got %0d want 2", ack_n); end
  endtask

  task automatic test_reset_mid;
    int rv_seen;
    int done_seen;
    exp_lat = 2 * LAT - 1;
    rd_base = 16'h5500;
    rv_seen = 0;
    done_seen = 0;
    @(posedge clk0_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 22'h00040; len_i = 8'd3;
    @(posedge clk0_i); #1;
    req_i = 1'b0;
    repeat (6) @(posedge clk0_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk0_i);
    n_cmp++; if ({cs_n_o, io_oe_clk_o, io_oe_data_o} !== 3'b010) begin n_err++; $display("FAIL mid_in_latw: got %b want 010", {cs_n_o, io_oe_clk_o, io_oe_data_o}); end
    @(posedge clk0_i); #1;
    rst_i = 1'b0;
    @(negedge clk0_i);
    n_cmp++; if ({cs_n_o, io_oe_clk_o, io_oe_data_o, rwds_oe_o} !== 4'b1000) begin n_err++; $display("FAIL mid_reset_outs: got %b want 1000", {cs_n_o, io_oe_clk_o, io_oe_data_o, rwds_oe_o}); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk0_i);
      if (rvalid_o) rv_seen++;
      if (done_o) done_seen++;
    end
    n_cmp++; if (rv_seen !== 0 || done_seen !== 0) begin n_err++; $display("FAIL mid_quiet: got rvalid %0d done %0d want 0 0", rv_seen, done_seen); end
  endtask

  task automatic test_long_read;
    exp_lat = 2 * LAT - 1;
    rd_base = 16'h1000;
    run_txn(1'b0, 22'h00100, 8'd255, 1, 400);
    n_cmp++; if (rv_n !== 256) begin n_err++; $display("FAIL long_count: got %0d want 256", rv_n); end
    n_cmp++; if (rv_err !== 0 || rv_gap !== 0) begin n_err++; $display("FAIL long_order: got %0d bad %0d gaps want 0 0", rv_err, rv_gap); end
    n_cmp++; if (rv_first !== 19 || rv_last !== 274) begin n_err++; $display("FAIL long_window: got %0d..%0d want 19..274", rv_first, rv_last); end
    n_cmp++; if (done_c[0] !== 278) begin n_err++; $display("FAIL long_done: got %0d want 278", done_c[0]); end
  endtask

  task automatic test_latency_select;
`ifdef HRAM_VARLAT_EN
    rwds_in_i = 1'b0;
    exp_lat = LAT - 1;
    run_txn(1'b1, 22'h00008, 8'd0, 1, 100);
    n_cmp++; if (oc_n !== 5) begin n_err++; $display("FAIL varlat_short: got %0d want 5", oc_n); end
    n_cmp++; if (done_c[0] !== 15) begin n_err++; $display("FAIL varlat_short_done: got %0d want 15", done_c[0]); end
    rwds_in_i = 1'b1;
    exp_lat = 2 * LAT - 1;
    run_txn(1'b1, 22'h00008, 8'd0, 1, 100);
    n_cmp++; if (oc_n !== 11) begin n_err++; $display("FAIL varlat_long: got %0d want 11", oc_n); end
    n_cmp++; if (done_c[0] !== 21) begin n_err++; $display("FAIL varlat_long_done: got %0d want 21", done_c[0]); end
`else
    rwds_in_i = 1'b0;
    exp_lat = 2 * LAT - 1;
    run_txn(1'b1, 22'h00008, 8'd0, 1, 100);
    n_cmp++; if (oc_n !== 11) begin n_err++; $display("FAIL fixedlat: got %0d want 11", oc_n); end
    n_cmp++; if (done_c[0] !== 21) begin n_err++; $display("FAIL fixedlat_done: got %0d want 21", done_c[0]); end
`endif
    rwds_in_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_single();
    test_back_to_back();
    test_reset_mid();
    test_long_read();
    test_latency_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
